// File: rtl/run_det_pkg.sv
// run_det_pkg: state encoding, mode constants and helper functions shared by
// the run-length detector and its bench.
`default_nettype none

package run_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN0 = 2'b01,
    RUN1 = 2'b10
  } state_t;

  localparam logic [1:0] MODE_ANY  = 2'b00;
  localparam logic [1:0] MODE_ZERO = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  function automatic int run_cnt_width(input int run_len);
    return $clog2(run_len + 1);
  endfunction

  // True when a run of polarity bit_val is allowed to detect under mode.
  function automatic logic mode_allows(input logic [1:0] mode, input logic bit_val);
    case (mode)
      MODE_ANY:  return 1'b1;
      MODE_ZERO: return ~bit_val;
      MODE_ONE:  return bit_val;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// sat_counter: counter with synchronous clear, load-to-one and saturating increment.
`default_nettype none

module sat_counter #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // clr outranks load1, which outranks inc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (load1) begin
      r_count <= WIDTH'(1);
    end else if (inc && (r_count != MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/run_length_detector.sv
// run_length_detector: tracks runs of equal serial samples, flags runs of
// RUN_LEN qualified by mode, and counts detection events.
`default_nettype none

module run_length_detector
  import run_det_pkg::*;
#(
  parameter  int RUN_LEN = 4,
  parameter  int HIT_W   = 8,
  localparam int CNT_W   = run_cnt_width(RUN_LEN)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             en,
  input  logic             w,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic             z,
  output logic             run_bit,
  output logic [CNT_W-1:0] run_count,
  output logic [HIT_W-1:0] hits,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] c_run_max = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] c_run_pre = CNT_W'(RUN_LEN - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_load1;
  logic             w_inc;
  logic             w_cnt_clr;
  logic             w_hit;
  logic [CNT_W-1:0] w_run_count;
  logic [HIT_W-1:0] w_hits;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_load1   = 1'b0;
    w_inc     = 1'b0;
    w_cnt_clr = clear;
    if (clear) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (en) begin
            w_next  = w ? RUN1 : RUN0;
            w_load1 = 1'b1;
          end
        end
        RUN0, RUN1: begin
          if (en) begin
            if (w == run_bit) begin
              w_inc = 1'b1;
            end else begin
              w_next  = w ? RUN1 : RUN0;
              w_load1 = 1'b1;
            end
          end
        end
        default: begin
          // Unreachable encoding: fall back to IDLE with an empty run.
          w_next    = IDLE;
          w_cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // A hit is the increment that lands exactly on RUN_LEN, so a saturated run
  // that keeps going is counted only once.
  assign w_hit = w_inc && (w_run_count == c_run_pre) && mode_allows(mode, w);

  sat_counter #(
    .WIDTH (CNT_W),
    .MAX   (c_run_max)
  ) u_run_cnt (
    .clk   (Clock),
    .rst   (Reset),
    .clr   (w_cnt_clr),
    .load1 (w_load1),
    .inc   (w_inc),
    .count (w_run_count)
  );

  sat_counter #(
    .WIDTH (HIT_W),
    .MAX   ({HIT_W{1'b1}})
  ) u_hit_cnt (
    .clk   (Clock),
    .rst   (Reset),
    .clr   (clear),
    .load1 (1'b0),
    .inc   (w_hit),
    .count (w_hits)
  );

  assign run_bit   = (r_state == RUN1);
  assign z         = (w_run_count == c_run_max) && mode_allows(mode, run_bit);
  assign run_count = w_run_count;
  assign hits      = w_hits;
  assign state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_run_length_detector.sv
// tb_run_length_detector: directed and random stimulus checked against a
// sample-history reference model of the run-length detector.
`default_nettype none

module tb_run_length_detector;

  localparam int RUN_LEN = 4;
  localparam int HIT_W   = 8;
  localparam int CNT_W   = $clog2(RUN_LEN + 1);
  localparam int HMAX    = (1 << HIT_W) - 1;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic             en    = 1'b0;
  logic             w     = 1'b0;
  logic [1:0]       mode  = 2'b00;
  logic             clear = 1'b0;
  logic             z;
  logic             run_bit;
  logic [CNT_W-1:0] run_count;
  logic [HIT_W-1:0] hits;
  logic [1:0]       state;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: recent enabled samples since reset/clear plus hit count.
  bit q[$];
  int m_hits = 0;

  run_length_detector #(
    .RUN_LEN (RUN_LEN),
    .HIT_W   (HIT_W)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .en        (en),
    .w         (w),
    .mode      (mode),
    .clear     (clear),
    .z         (z),
    .run_bit   (run_bit),
    .run_count (run_count),
    .hits      (hits),
    .state     (state)
  );

  always #5 Clock = ~Clock;

  function automatic bit allow(input logic [1:0] m, input bit b);
    return (m == 2'd0) || (m == 2'd1 && !b) || (m == 2'd2 && b);
  endfunction

  function automatic int raw_run();
    int n = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i] == q[q.size()-1]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_reset();
    q.delete();
    m_hits = 0;
  endtask

  task automatic model_edge(input logic e, input logic wi, input logic c);
    if (c) begin
      model_reset();
    end else if (e) begin
      q.push_back(wi);
      if (q.size() > RUN_LEN + 1) void'(q.pop_front());
      if (raw_run() == RUN_LEN && allow(mode, wi) && m_hits < HMAX) m_hits++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int  e_cnt;
    bit  e_bit;
    e_cnt = (q.size() == 0) ? 0 : ((raw_run() > RUN_LEN) ? RUN_LEN : raw_run());
    e_bit = (q.size() == 0) ? 1'b0 : q[q.size()-1];
    chk({tag, "_state"}, 32'(state), (q.size() == 0) ? 32'd0 : (e_bit ? 32'd2 : 32'd1));
    chk({tag, "_run_bit"}, 32'(run_bit), 32'(e_bit));
    chk({tag, "_run_count"}, 32'(run_count), 32'(e_cnt));
    chk({tag, "_z"}, 32'(z), 32'((e_cnt == RUN_LEN) && allow(mode, e_bit)));
    chk({tag, "_hits"}, 32'(hits), 32'(m_hits));
  endtask

  task automatic step(input string tag, input logic e, input logic wi, input logic c);
    en    = e;
    w     = wi;
    clear = c;
    @(posedge Clock);
    model_edge(e, wi, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic prev_w;

    // Reset state
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    check_all("reset");
    Reset = 1'b0;

    // Five zeros, mode any
    mode = 2'b00;
    for (int i = 0; i < 5; i++) step("s1", 1'b1, 1'b0, 1'b0);
    chk("s1_hits_const", 32'(hits), 32'd1);
    chk("s1_z_const", 32'(z), 32'd1);

    // 1,1,1,0,1,1,1,1 after a clear
    step("s2_clr", 1'b1, 1'b0, 1'b1);
    foreach (q[i]) ;
    begin
      logic [7:0] pat;
      pat = 8'b11110111;
      for (int i = 0; i < 8; i++) step("s2", 1'b1, pat[i], 1'b0);
    end
    chk("s2_hits_const", 32'(hits), 32'd1);

    // Ones under zeros-only mode, then mode switch without an edge
    step("s3_clr", 1'b1, 1'b0, 1'b1);
    mode = 2'b01;
    for (int i = 0; i < 4; i++) step("s3", 1'b1, 1'b1, 1'b0);
    chk("s3_z_off", 32'(z), 32'd0);
    mode = 2'b10;
    #1;
    check_all("s3_mode");
    chk("s3_z_on", 32'(z), 32'd1);
    chk("s3_hits0", 32'(hits), 32'd0);

    // Gap in en does not break a run; w ignored while en=0
    mode = 2'b00;
    step("s4_clr", 1'b1, 1'b0, 1'b1);
    step("s4a", 1'b1, 1'b0, 1'b0);
    step("s4a", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("s4gap", 1'b0, 1'b1, 1'b0);
    step("s4b", 1'b1, 1'b0, 1'b0);
    step("s4b", 1'b1, 1'b0, 1'b0);
    chk("s4_z", 32'(z), 32'd1);

    // Hit counter saturation, then clear with simultaneous sample
    step("s5_clr", 1'b1, 1'b0, 1'b1);
    for (int r = 0; r < 300; r++)
      for (int i = 0; i < 4; i++) step("s5", 1'b1, 1'(r & 1), 1'b0);
    chk("s5_sat", 32'(hits), 32'd255);
    step("s5_clr_en", 1'b1, 1'b1, 1'b1);
    chk("s5_cleared", 32'(hits), 32'd0);

    // Asynchronous reset mid-run
    for (int i = 0; i < 3; i++) step("s6", 1'b1, 1'b0, 1'b0);
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    check_all("s6_async");
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) step("s6_post", 1'b1, 1'b0, 1'b0);
    chk("s6_z0", 32'(z), 32'd0);

    // Random stimulus with biased run continuation
    prev_w = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic e, wi, c;
      e  = ($urandom_range(0, 3) != 0);
      wi = ($urandom_range(0, 3) != 0) ? prev_w : 1'($urandom);
      c  = ($urandom_range(0, 59) == 0);
      prev_w = wi;
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      step("rnd", e, wi, c);
      if ($urandom_range(0, 19) == 0) begin
        mode = 2'($urandom_range(0, 3));
        #1;
        check_all("rnd_mode");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/run_length_detector.md
# run_length_detector

- Parametrised successor to the lab-7 one-hot "four equal inputs in a row" FSM.
- Samples a serial input `w` on qualified clock edges and tracks the current run of identical bits in a binary-encoded state plus saturating run counter.
- Asserts `z` once `RUN_LEN` consecutive equal bits have been seen, subject to a run-polarity mode.
- Also keeps a saturating count of detection events; sits between the switch/key debounce logic and the LED/7-segment display drivers.

## Interface

Parameters:
- `RUN_LEN`, default 4: consecutive equal samples required for detection; legal range 2..255.
- `HIT_W`, default 8: width of the detection-event counter.

Ports:
- `Clock` in 1: sole clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `en` in 1: sample strobe; `w` is sampled only on edges where `en`=1.
- `w` in 1: serial data input.
- `mode` in 2: which runs qualify.
  - 00 either polarity.
  - 01 zeros only.
  - 10 ones only.
  - 11 detection disabled; tracking continues.
- `clear` in 1: synchronous clear of state, run count and hit count.
- `z` out 1: detection flag.
- `run_bit` out 1: polarity of the current run; 0 in IDLE.
- `run_count` out `$clog2(RUN_LEN+1)`: length of the current run, saturating at `RUN_LEN`.
- `hits` out `HIT_W`: number of detection events, saturating at all-ones.
- `state` out 2: encoded FSM state for debug LEDs.

## Operation

States:
- IDLE = 00: no sample taken since reset or clear.
- RUN0 = 01: current run is zeros.
- RUN1 = 10: current run is ones.
- Encoding 11 is illegal and recovers to IDLE on the next edge.

On an edge with `en`=1 and `clear`=0:
- From IDLE: go to RUN0 or RUN1 according to `w`; `run_count` ← 1.
- In RUNx with `w` equal to x: stay; `run_count` ← min(`run_count`+1, `RUN_LEN`).
- In RUNx with `w` not equal to x: move to the other RUN state; `run_count` ← 1. This reproduces the lab behaviour where a changed bit starts a new run of length 1.

Detection output:
- `z` = (`run_count` == `RUN_LEN`) AND the polarity of `run_bit` is allowed by `mode`.
- `z` is decoded combinationally from registered state and the current `mode` (Moore plus quasi-static qualifier).

Hit counter:
- `hits` increments on an enabled edge where `run_count` goes from `RUN_LEN`-1 to `RUN_LEN` and the new run's polarity is allowed by `mode` at that edge.
- Continuing a saturated run does not increment `hits`.
- `hits` saturates at 2^`HIT_W`-1.

Priorities and holds:
- `clear`=1 has priority over `en`: next state IDLE, `run_count` 0, `hits` 0.
- `en`=0 and `clear`=0: all registers hold.

Reset values (asynchronous): `state` IDLE, `run_count` 0, `run_bit` 0, `z` 0, `hits` 0.

## Timing

- Latency: `z` rises in the cycle after the edge that samples the `RUN_LEN`-th equal bit. There is no extra pipeline stage.
- `z` falls after the first enabled edge that samples an opposite bit.
- A `mode` change affects `z` in the same cycle, with no edge required.
- A `mode` change never retroactively changes `hits`.
- Reset mid-run: all outputs go to reset values immediately, independent of `Clock`. After release, the first enabled sample is treated as run length 1.
- Gaps in `en` of any length do not break a run.
- Simultaneous `clear` and an `en` sample: the sample is discarded.

## Structure

Shared package `run_det_pkg` holds:
- The state enum (IDLE, RUN0, RUN1).
- The mode constants (MODE_ANY, MODE_ZERO, MODE_ONE, MODE_OFF).
- A function that computes the run-counter width from `RUN_LEN`.

Sub-module `sat_counter` (parameters WIDTH, MAX; inputs `clr`, `load1`, `inc`) is instantiated twice:
- Once for `run_count`.
- Once for `hits`.

The top level contains the FSM, the qualifier decode and the hit-event detect.

## Test plan

All scenarios use `RUN_LEN`=4, `HIT_W`=8, `en`=1 unless stated.
- Reset, then `w`=0,0,0,0,0 with `mode`=00 → `z`=1 after the 4th edge and stays 1 after the 5th; `run_count`=4; `hits`=1; `state`=01.
- `w`=1,1,1,0,1,1,1,1 with `mode`=00 → `z` stays 0 through edge 7 and goes 1 after edge 8; `hits`=1; the run restarts at edge 4 and edge 5.
- Four 1s with `mode`=01 → `z`=0 and `hits`=0. Switching `mode` to 10 without a clock edge → `z`=1 immediately, `hits` still 0.
- `w`=0,0 then `en`=0 for 10 cycles, then `w`=0,0 → `z`=1 after the 4th enabled edge. `w`=1 sampled while `en`=0 has no effect.
- 300 alternating runs of four 0s and four 1s with `mode`=00 → `hits` saturates at 255. Then `clear`=1 together with `en`=1 → `state` IDLE, `run_count` 0, `hits` 0.
- Assert `Reset` asynchronously mid-run at `run_count`=3 → all outputs reset before the next edge. After release, three 0s → `z`=0.
